// File: rtl/lighthouse_emitter_if.sv
// lighthouse_emitter_if: control inputs and waveform outputs of the lighthouse emitter
interface lighthouse_emitter_if #(
  parameter int WIDTH = 24
);
  logic             enable;
  logic [2:0]       sync0_code;
  logic [2:0]       sync1_code;
  logic [WIDTH-1:0] sweep_time;
  logic             pin_out;
  logic             frame_strobe;
  logic             sweep_strobe;
  logic             sweep_skipped;
  logic             busy;
  modport master (
    output enable, sync0_code, sync1_code, sweep_time,
    input  pin_out, frame_strobe, sweep_strobe, sweep_skipped, busy
  );
  modport slave (
    input  enable, sync0_code, sync1_code, sweep_time,
    output pin_out, frame_strobe, sweep_strobe, sweep_skipped, busy
  );
endinterface

// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter: sync0/sync1/sweep optical waveform generator; define LIGHTHOUSE_EMITTER_AXIS_TOGGLE_EN to alternate the axis bit every frame
module lighthouse_emitter #(
  parameter int WIDTH                  = 24,
  parameter int CLOCKS_PER_MICROSECOND = 48,
  parameter int FRAME_CLOCKS           = 399984,
  parameter int SYNC_GAP_CLOCKS        = 19200,
  parameter int SYNC_BASE_CLOCKS       = 3000,
  parameter int SYNC_STEP_CLOCKS       = 500,
  parameter int SWEEP_WIDTH_CLOCKS     = 480
) (
  input logic              clk,
  input logic              reset,
  lighthouse_emitter_if.slave bus
);
  localparam logic [WIDTH-1:0] F_LAST = WIDTH'(FRAME_CLOCKS - 1);
  localparam logic [WIDTH-1:0] GAP_C  = WIDTH'(SYNC_GAP_CLOCKS);
  localparam logic [WIDTH-1:0] BASE   = WIDTH'(SYNC_BASE_CLOCKS);
  localparam logic [WIDTH-1:0] STEP   = WIDTH'(SYNC_STEP_CLOCKS);
  localparam logic [WIDTH-1:0] SW     = WIDTH'(SWEEP_WIDTH_CLOCKS);
  localparam logic [WIDTH-1:0] HALF   = WIDTH'(SWEEP_WIDTH_CLOCKS / 2);

  if (SWEEP_WIDTH_CLOCKS % 2 != 0 || CLOCKS_PER_MICROSECOND < 1) begin : g_bad_cfg
    $error("lighthouse_emitter: SWEEP_WIDTH_CLOCKS must be even and CLOCKS_PER_MICROSECOND positive");
  end

  typedef enum logic [2:0] {IDLE, SYNC0, GAP, SYNC1, WAIT, SWEEP, TAIL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] t, tn, len0, r1, fall;
  logic [WIDTH-1:0] len0_n, len1_n, r1_n, fall_n;
  logic [WIDTH:0]   end_n;
  logic             valid, valid_n, last, start, sweep_end;
  logic [2:0]       code0, code1;

  assign tn    = t + WIDTH'(1);
  assign last  = state != IDLE && t == F_LAST;
  assign start = bus.enable && (state == IDLE || last);

`ifdef LIGHTHOUSE_EMITTER_AXIS_TOGGLE_EN
  logic axis, axis_n;
  assign axis_n = state == IDLE ? 1'b0 : ~axis;
  assign code0  = {bus.sync0_code[2:1], axis_n};
  assign code1  = {bus.sync1_code[2:1], axis_n};
  always_ff @(posedge clk or posedge reset)
    if (reset) axis <= 1'b0;
    else if (start) axis <= axis_n;
`else
  assign code0 = bus.sync0_code;
  assign code1 = bus.sync1_code;
`endif

  // Frame geometry is fixed at frame start so mid-frame input changes are ignored
  assign len0_n  = BASE + STEP * WIDTH'(code0);
  assign len1_n  = BASE + STEP * WIDTH'(code1);
  assign r1_n    = GAP_C + len1_n;
  assign fall_n  = r1_n + bus.sweep_time - HALF;
  assign end_n   = {1'b0, r1_n} + {1'b0, bus.sweep_time} + {1'b0, HALF};
  assign valid_n = bus.sweep_time >= HALF && end_n <= {1'b0, F_LAST};

  always_comb begin
    state_n   = state;
    sweep_end = 1'b0;
    if (state == IDLE || last) state_n = start ? SYNC0 : IDLE;
    else
      unique case (state)
        SYNC0:   state_n = tn == len0 ? GAP : SYNC0;
        GAP:     state_n = tn == GAP_C ? SYNC1 : GAP;
        SYNC1:   state_n = tn != r1 ? SYNC1 : !valid ? TAIL : tn == fall ? SWEEP : WAIT;
        WAIT:    state_n = tn == fall ? SWEEP : WAIT;
        SWEEP: begin
          sweep_end = tn == fall + SW;
          state_n   = sweep_end ? TAIL : SWEEP;
        end
        default: state_n = state;
      endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state             <= IDLE;
      t                 <= '0;
      len0              <= '0;
      r1                <= '0;
      fall              <= '0;
      valid             <= 1'b0;
      bus.pin_out       <= 1'b1;
      bus.frame_strobe  <= 1'b0;
      bus.sweep_strobe  <= 1'b0;
      bus.sweep_skipped <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      state <= state_n;
      t     <= (state_n == IDLE || start) ? '0 : tn;
      if (start) begin
        len0  <= len0_n;
        r1    <= r1_n;
        fall  <= fall_n;
        valid <= valid_n;
      end
      bus.pin_out       <= !(state_n inside {SYNC0, SYNC1, SWEEP});
      bus.frame_strobe  <= start;
      bus.sweep_strobe  <= sweep_end;
      bus.sweep_skipped <= start ? !valid_n : state_n == IDLE ? 1'b0 : bus.sweep_skipped;
      bus.busy          <= state_n != IDLE;
    end
endmodule

// File: tb/tb_lighthouse_emitter.sv
// tb_lighthouse_emitter: table-driven frame checks on a scaled-down emitter (F=1000, gap=200, base=60, step=10, sweep=20)
module tb_lighthouse_emitter;
  localparam int F = 1000;

  typedef struct {
    int c0, c1, st, mid, len0, len1, fall, skip;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0, errors = 0, fidx = 0;
  int   nseg, gap_n, fs_cnt, bz_cnt, sk_cnt, ss_cnt, ss_t;
  int   seg_start[4], seg_len[4];
  vec_t vecs[9];

  lighthouse_emitter_if #(.WIDTH(16)) bus ();

  lighthouse_emitter #(
    .WIDTH(16), .CLOCKS_PER_MICROSECOND(1), .FRAME_CLOCKS(F), .SYNC_GAP_CLOCKS(200),
    .SYNC_BASE_CLOCKS(60), .SYNC_STEP_CLOCKS(10), .SWEEP_WIDTH_CLOCKS(20)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  task automatic measure(input int mid, input int drop, input int raise);
    int   n = 0;
    logic prev = 1'b1;
    nseg = 0; fs_cnt = 0; bz_cnt = 0; sk_cnt = 0; ss_cnt = 0; ss_t = -1;
    for (int k = 0; k < 4; k++) begin seg_start[k] = -1; seg_len[k] = 0; end
    @(negedge clk);
    while (!bus.frame_strobe && n < 3 * F) begin @(negedge clk); n++; end
    gap_n = n;
    chk("frame_start", int'(bus.frame_strobe), 1);
    if (!bus.frame_strobe) return;
    for (int t = 0; t < F; t++) begin
      if (t > 0) @(negedge clk);
      if (!bus.pin_out && prev) begin
        if (nseg < 4) seg_start[nseg] = t;
        nseg++;
      end
      if (!bus.pin_out && nseg > 0 && nseg <= 4) seg_len[nseg-1]++;
      prev = bus.pin_out;
      if (bus.frame_strobe) fs_cnt++;
      if (bus.busy) bz_cnt++;
      if (bus.sweep_skipped) sk_cnt++;
      if (bus.sweep_strobe) begin ss_cnt++; ss_t = t; end
      if (t == 10 && mid >= 0) bus.sweep_time = 16'(mid);
      if (t == drop) bus.enable = 1'b0;
      if (t == raise) bus.enable = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int c0, input int c1, input int st,
                             input int len0, input int len1, input int fall, input int skip);
`ifdef LIGHTHOUSE_EMITTER_AXIS_TOGGLE_EN
    int a  = fidx & 1;
    int d0 = 10 * (((c0 & 6) | a) - c0);
    int d1 = 10 * (((c1 & 6) | a) - c1);
    len0 += d0;
    len1 += d1;
    fall += d1;
    skip = (st < 10 || 200 + len1 + st + 10 > F - 1) ? 1 : 0;
`endif
    int merged = (skip == 0 && fall == 200 + len1) ? 1 : 0;
    chk({tag, " gapless"}, gap_n, 0);
    chk({tag, " frame_strobe count"}, fs_cnt, 1);
    chk({tag, " busy cycles"}, bz_cnt, F);
    chk({tag, " sync0 start"}, seg_start[0], 0);
    chk({tag, " sync0 len"}, seg_len[0], len0);
    chk({tag, " sync1 start"}, seg_start[1], 200);
    chk({tag, " sync1 len"}, seg_len[1], len1 + 20 * merged);
    chk({tag, " low pulses"}, nseg, (skip != 0 || merged != 0) ? 2 : 3);
    chk({tag, " skipped cycles"}, sk_cnt, skip != 0 ? F : 0);
    chk({tag, " sweep_strobe count"}, ss_cnt, skip != 0 ? 0 : 1);
    if (skip == 0) chk({tag, " sweep_strobe t"}, ss_t, fall + 20);
    if (skip == 0 && merged == 0) begin
      chk({tag, " sweep start"}, seg_start[2], fall);
      chk({tag, " sweep len"}, seg_len[2], 20);
    end
    fidx++;
  endtask

  task automatic set_in(input int c0, input int c1, input int st);
    bus.sync0_code = 3'(c0);
    bus.sync1_code = 3'(c1);
    bus.sweep_time = 16'(st);
    bus.enable     = 1'b1;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0, 0, 300, -1,  60,  60, 550, 0};
    vecs[1] = '{5, 2, 300, -1, 110,  80, 570, 0};
    vecs[2] = '{0, 0,   9, -1,  60,  60,   0, 1};
    vecs[3] = '{0, 0, 300, -1,  60,  60, 550, 0};
    vecs[4] = '{0, 0,  10, -1,  60,  60, 260, 0};
    vecs[5] = '{0, 0, 729, -1,  60,  60, 979, 0};
    vecs[6] = '{0, 0, 730, -1,  60,  60,   0, 1};
    vecs[7] = '{7, 7, 300, 50, 130, 130, 620, 0};
    vecs[8] = '{0, 0,  50, -1,  60,  60, 300, 0};
    reset = 1'b1;
    bus.enable = 1'b0; bus.sync0_code = '0; bus.sync1_code = '0; bus.sweep_time = '0;
    repeat (2) @(negedge clk);
    chk("reset pin_out", int'(bus.pin_out), 1);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset frame_strobe", int'(bus.frame_strobe), 0);
    chk("reset sweep_strobe", int'(bus.sweep_strobe), 0);
    chk("reset sweep_skipped", int'(bus.sweep_skipped), 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].c0, vecs[i].c1, vecs[i].st);
      measure(vecs[i].mid, -1, -1);
      check_frame($sformatf("v%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].st,
                  vecs[i].len0, vecs[i].len1, vecs[i].fall, vecs[i].skip);
    end
    set_in(0, 0, 300);
    measure(-1, 5, 500);
    check_frame("reassert", 0, 0, 300, 60, 60, 550, 0);
    measure(-1, 5, -1);
    check_frame("drop", 0, 0, 300, 60, 60, 550, 0);
    @(negedge clk);
    chk("drop busy after end", int'(bus.busy), 0);
    chk("drop pin idle", int'(bus.pin_out), 1);
    cnt = 0;
    repeat (50) begin @(negedge clk); if (bus.frame_strobe) cnt++; end
    chk("drop no further frame", cnt, 0);
    set_in(0, 0, 300);
    @(negedge clk);
    chk("rst seq frame_strobe", int'(bus.frame_strobe), 1);
    repeat (210) @(negedge clk);
    chk("rst seq in sync1", int'(bus.pin_out), 0);
    #2 reset = 1'b1;
    #1;
    chk("async reset pin_out", int'(bus.pin_out), 1);
    chk("async reset busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("reset held skipped", int'(bus.sweep_skipped), 0);
    reset = 1'b0;
    fidx = 0;
    measure(-1, -1, -1);
    check_frame("after reset", 0, 0, 300, 60, 60, 550, 0);
    bus.enable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
